vga_sync: RTL

// - Scan-timing generator for the 640x480@60 Hz VGA path; drives the h_count/v_count bus read by the pixel/draw stage.
// - Produces registered hsync/vsync to the connector, plus video_on and per-line/per-frame strobes.
// - Counter origin is the start of the sync pulse, so visible pixels occupy h 144..783, v 35..514.
// - The draw stage applies its own porch window inside these counts.

---
 rtl/vga_sync.sv | 87 ++++++++
 1 files changed

// File: rtl/vga_sync.sv
// Scan-timing generator for a 640x480@60 VGA path. The counters start at the beginning of the sync pulse.
// Every output is registered from the next-count value, so it lines up with the h_count/v_count shown in the same cycle.
module vga_sync #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 515,
    parameter bit SYNC_NEG    = 1'b1
) (
    input  logic       clk_25,
    input  logic       rst,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYN   = 10'(H_SYNC);
    localparam logic [9:0] V_SYN   = 10'(V_SYNC);
    localparam logic [9:0] H_VIS_S = 10'(H_VIS_START);
    localparam logic [9:0] H_VIS_E = 10'(H_VIS_END);
    localparam logic [9:0] V_VIS_S = 10'(V_VIS_START);
    localparam logic [9:0] V_VIS_E = 10'(V_VIS_END);

    logic [9:0] h_reg, v_reg, h_next, v_next;
    logic       h_wrap, v_wrap;
    logic       hsync_reg, vsync_reg, video_on_reg, line_start_reg, frame_start_reg;
    logic [7:0] frame_count_reg;

    always_comb begin
        h_wrap = (h_reg == H_LAST);
        v_wrap = h_wrap && (v_reg == V_LAST);
        h_next = h_wrap ? 10'd0 : h_reg + 10'd1;
        v_next = v_reg;
        if (v_wrap) begin
            v_next = 10'd0;
        end else if (h_wrap) begin
            v_next = v_reg + 10'd1;
        end
    end

    // XOR with SYNC_NEG turns "inside the sync window" into the pin level.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            h_reg           <= 10'd0;
            v_reg           <= 10'd0;
            hsync_reg       <= ~SYNC_NEG;
            vsync_reg       <= ~SYNC_NEG;
            video_on_reg    <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_count_reg <= 8'd0;
        end else begin
            h_reg           <= h_next;
            v_reg           <= v_next;
            hsync_reg       <= (h_next < H_SYN) ^ SYNC_NEG;
            vsync_reg       <= (v_next < V_SYN) ^ SYNC_NEG;
            video_on_reg    <= (h_next >= H_VIS_S) && (h_next < H_VIS_E) &&
                               (v_next >= V_VIS_S) && (v_next < V_VIS_E);
            line_start_reg  <= h_wrap;
            frame_start_reg <= v_wrap;
            if (v_wrap) begin
                frame_count_reg <= frame_count_reg + 8'd1;
            end
        end
    end

    assign h_count     = h_reg;
    assign v_count     = v_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign video_on    = video_on_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;
    assign frame_count = frame_count_reg;

endmodule
